// File: rtl/ssp_tx_serializer.sv
// SSP transmit back end: pops bytes from the TX FIFO and shifts them out MSB-first
// as SSI frames (one frame-sync bit period followed by DATA_W data bit periods).
module ssp_tx_serializer #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ssp_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              ssp_clk_out,
  output logic              ssp_fss_out,
  output logic              ssp_txd,
  output logic              tx_busy
);
  // state | meaning
  // IDLE  | waiting for ssp_en with a non-empty FIFO
  // POP   | one-cycle fifo_read strobe
  // LOAD  | FIFO read data captured into the shift register
  // FRAME | frame-sync bit period, fss high, txd low
  // SHIFT | DATA_W data bit periods, MSB first

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, FRAME, SHIFT} state_t;

  state_t             state;
  logic [DATA_W-1:0]  shift_reg;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_inc;
  logic [BIT_W-1:0]   bit_cnt;
  logic               period_end;
  logic               start_ok;

  assign div_inc    = div_cnt + DIV_W'(1);
  assign period_end = (div_cnt == DIV_LAST);
  assign start_ok   = ssp_en && !fifo_empty;
  assign fifo_read  = (state == POP);
  assign tx_busy    = (state != IDLE);

  // Outputs are registered from the upcoming cycle's position in the bit period,
  // so ssp_clk_out is high for div_cnt < CLK_DIV of every FRAME/SHIFT period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      shift_reg   <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      ssp_clk_out <= 1'b0;
      ssp_fss_out <= 1'b0;
      ssp_txd     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) state <= POP;
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg   <= fifo_data;
          div_cnt     <= '0;
          bit_cnt     <= '0;
          ssp_clk_out <= 1'b1;
          ssp_fss_out <= 1'b1;
          ssp_txd     <= 1'b0;
          state       <= FRAME;
        end
        FRAME: begin
          if (period_end) begin
            div_cnt     <= '0;
            ssp_clk_out <= 1'b1;
            ssp_fss_out <= 1'b0;
            ssp_txd     <= shift_reg[DATA_W-1];
            state       <= SHIFT;
          end else begin
            div_cnt     <= div_inc;
            ssp_clk_out <= (div_inc < DIV_HALF);
          end
        end
        SHIFT: begin
          if (period_end) begin
            div_cnt   <= '0;
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt     <= '0;
              ssp_clk_out <= 1'b0;
              ssp_txd     <= 1'b0;
              state       <= start_ok ? POP : IDLE;
            end else begin
              bit_cnt     <= bit_cnt + BIT_W'(1);
              ssp_clk_out <= 1'b1;
              ssp_txd     <= shift_reg[DATA_W-2];
            end
          end else begin
            div_cnt     <= div_inc;
            ssp_clk_out <= (div_inc < DIV_HALF);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
